// File: rtl/sdram_read.sv
// Single-access SDRAM read sequencer: ACTIVE -> READ (auto-precharge) -> capture a BURST_LEN-word burst.
// Optional feature macro SDRAM_READ_CNT_EN adds the ordcnt completed-read counter.
module sdram_read #(
    parameter int CAS_LATENCY = 2,
    parameter int BURST_LEN   = 1,
    parameter int TRCD_CYC    = 1
) (
    input  logic        iclk,
    input  logic        ireset_n,
    input  logic        ireq,
    input  logic        ienb,
    output logic        ofin,
    input  logic [12:0] irow,
    input  logic [9:0]  icolumn,
    input  logic [1:0]  ibank,
    output logic [15:0] odata,
    output logic        ovalid,
`ifdef SDRAM_READ_CNT_EN
    output logic [15:0] ordcnt,
`endif
    output logic        DRAM_CLK,
    output logic        DRAM_CKE,
    output logic [12:0] DRAM_ADDR,
    output logic [1:0]  DRAM_BA,
    output logic        DRAM_CS_N,
    output logic        DRAM_RAS_N,
    output logic        DRAM_CAS_N,
    output logic        DRAM_WE_N,
    output logic        DRAM_LDQM,
    output logic        DRAM_UDQM,
    input  logic [15:0] DRAM_DQ
);

    typedef enum logic [2:0] {
        IDLE, RD_ACT, RD_NOP1, RD_READ, RD_WAIT, RD_CAPT, RD_NOP2, RD_FIN
    } state_e;

    localparam logic [3:0] CMD_NOP  = 4'b0111;
    localparam logic [3:0] CMD_BACT = 4'b0011;
    localparam logic [3:0] CMD_READ = 4'b0101;

    localparam logic [3:0] TRCD_LAST = 4'(TRCD_CYC - 1);
    localparam logic [3:0] CL_LAST   = 4'(CAS_LATENCY - 1);
    localparam logic [3:0] BL_LAST   = 4'(BURST_LEN - 1);

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [3:0]  wcnt_q, wcnt_d;
    logic [3:0]  cmd_q, cmd_d;
    logic [12:0] addr_q, addr_d;
    logic [1:0]  ba_q, ba_d;
    logic [1:0]  dqm_q, dqm_d;
    logic [15:0] odata_q, odata_d;
    logic        ovalid_q, ovalid_d;
    logic        ofin_q, ofin_d;
    logic [12:0] row_q, row_d;
    logic [9:0]  col_q, col_d;
    logic [1:0]  bank_q, bank_d;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q + 4'd1;
        wcnt_d   = wcnt_q;
        cmd_d    = CMD_NOP;
        addr_d   = addr_q;
        ba_d     = ba_q;
        dqm_d    = 2'b11;
        odata_d  = odata_q;
        ovalid_d = 1'b0;
        ofin_d   = 1'b0;
        row_d    = row_q;
        col_d    = col_q;
        bank_d   = bank_q;
        case (state_q)
            IDLE: begin
                if (ireq) begin
                    row_d   = irow;
                    col_d   = icolumn;
                    bank_d  = ibank;
                    state_d = RD_ACT;
                end
            end
            RD_ACT: begin
                cmd_d   = CMD_BACT;
                addr_d  = row_q;
                ba_d    = bank_q;
                state_d = RD_NOP1;
            end
            RD_NOP1: begin
                if (cnt_q == TRCD_LAST) state_d = RD_READ;
            end
            RD_READ: begin
                // A10 high requests auto-precharge so no explicit PRECHARGE is needed
                cmd_d   = CMD_READ;
                addr_d  = {3'b001, col_q};
                ba_d    = bank_q;
                dqm_d   = 2'b00;
                state_d = RD_WAIT;
            end
            RD_WAIT: begin
                dqm_d = 2'b00;
                if (cnt_q == CL_LAST) state_d = RD_CAPT;
            end
            RD_CAPT: begin
                dqm_d    = 2'b00;
                odata_d  = DRAM_DQ;
                ovalid_d = 1'b1;
                wcnt_d   = wcnt_q + 4'd1;
                if (wcnt_q == BL_LAST) state_d = RD_NOP2;
            end
            RD_NOP2: state_d = RD_FIN;
            RD_FIN: begin
                ofin_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (state_d != state_q) begin
            cnt_d  = 4'd0;
            wcnt_d = 4'd0;
        end
    end

    always_ff @(posedge iclk or negedge ireset_n) begin
        if (!ireset_n) begin
            state_q  <= IDLE;
            cnt_q    <= 4'd0;
            wcnt_q   <= 4'd0;
            cmd_q    <= CMD_NOP;
            addr_q   <= 13'd0;
            ba_q     <= 2'd0;
            dqm_q    <= 2'b11;
            odata_q  <= 16'd0;
            ovalid_q <= 1'b0;
            ofin_q   <= 1'b0;
            row_q    <= 13'd0;
            col_q    <= 10'd0;
            bank_q   <= 2'd0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            wcnt_q   <= wcnt_d;
            cmd_q    <= cmd_d;
            addr_q   <= addr_d;
            ba_q     <= ba_d;
            dqm_q    <= dqm_d;
            odata_q  <= odata_d;
            ovalid_q <= ovalid_d;
            ofin_q   <= ofin_d;
            row_q    <= row_d;
            col_q    <= col_d;
            bank_q   <= bank_d;
        end
    end

`ifdef SDRAM_READ_CNT_EN
    logic [15:0] ordcnt_q;

    // Counts on the same edge that raises ofin, saturating instead of wrapping
    always_ff @(posedge iclk or negedge ireset_n) begin
        if (!ireset_n) begin
            ordcnt_q <= 16'd0;
        end else if (ofin_d && ordcnt_q != 16'hFFFF) begin
            ordcnt_q <= ordcnt_q + 16'd1;
        end
    end

    assign ordcnt = ordcnt_q;
`endif

    assign odata  = odata_q;
    assign ovalid = ovalid_q;
    assign ofin   = ofin_q;

    // The command bus is shared with the init/write blocks, so release it without the grant
    assign DRAM_CLK   = ienb ? ~iclk     : 1'bz;
    assign DRAM_CKE   = ienb ? 1'b1      : 1'bz;
    assign DRAM_ADDR  = ienb ? addr_q    : {13{1'bz}};
    assign DRAM_BA    = ienb ? ba_q      : 2'bzz;
    assign DRAM_CS_N  = ienb ? cmd_q[3]  : 1'bz;
    assign DRAM_RAS_N = ienb ? cmd_q[2]  : 1'bz;
    assign DRAM_CAS_N = ienb ? cmd_q[1]  : 1'bz;
    assign DRAM_WE_N  = ienb ? cmd_q[0]  : 1'bz;
    assign DRAM_LDQM  = ienb ? dqm_q[0]  : 1'bz;
    assign DRAM_UDQM  = ienb ? dqm_q[1]  : 1'bz;

endmodule
